// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
//   ADDR_W        : byte-address width of the fetch path
//   INST_W        : instruction word width
//   fetch_entry_t : one prefetch FIFO entry, the word plus the address it came from
//   ptr_w()       : pointer width for a FIFO of a given depth
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle between the fetch unit, the core and the instruction memory.
//   Core side   : inst_addr (core -> fetch), in_valid/inst (fetch -> core)
//   Memory side : im_rd/im_addr (fetch -> mem), im_rvalid/im_rdata (mem -> fetch)
// Handshake: neither direction has a ready. The core consumes inst in every cycle
// in_valid is high. The memory accepts every im_rd pulse and answers each one with
// exactly one im_rvalid pulse some cycles later, in request order.
// The fetch unit connects through the master modport, the environment through slave.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] inst_addr;
  logic              in_valid;
  logic [31:0]       inst;
  logic              im_rd;
  logic [ADDR_W-1:0] im_addr;
  logic              im_rvalid;
  logic [31:0]       im_rdata;

  modport master (
    input  inst_addr, im_rvalid, im_rdata,
    output in_valid, inst, im_rd, im_addr
  );

  modport slave (
    output inst_addr, im_rvalid, im_rdata,
    input  in_valid, inst, im_rd, im_addr
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding prefetched {addr, data} entries.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write wr_entry at end of cycle (caller never pushes when full)
//   pop        : drop head at end of cycle (caller never pops when empty)
//   flush      : empty the FIFO at end of cycle, overriding push/pop
//   head       : oldest entry, valid when !empty
//   empty      : no entries
//   count      : current number of entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         empty,
  output logic [PW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage carries no reset; count alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage feeding the SP core from a variable-latency memory.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : inst_fetch_unit_if.master (core request/response + memory port)
//   done       : EXEC_NUM instructions delivered, sticky
//   addr_err   : sticky, core presented a misaligned inst_addr
// Build option FETCH_PREFETCH_EN: when defined the FIFO prefetches sequentially up
// to DEPTH entries; when undefined the effective depth is 1 (demand fetch).
// ADDR_W must equal fetch_pkg::ADDR_W since FIFO entries use the package width.
module inst_fetch_unit import fetch_pkg::*; #(
  parameter int DEPTH    = 4,
  parameter int EXEC_NUM = 500,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_fetch_unit_if.master   bus,
  output logic                done,
  output logic                addr_err
);

`ifdef FETCH_PREFETCH_EN
  localparam int EFF_DEPTH = DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif
  localparam int PW    = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(EXEC_NUM + 1);

  logic [ADDR_W-1:0] fp;         // next sequential address to request
  logic              pend;       // a request is outstanding
  logic              pend_drop;  // its response must be discarded
  logic [ADDR_W-1:0] pend_addr;
  logic [CNT_W-1:0]  exec_cnt;

  fetch_entry_t      head;
  fetch_entry_t      wr_entry;
  logic              fifo_empty;
  logic [PW:0]       fifo_count;
  logic [PW:0]       occ_next;

  logic              misaligned;
  logic [ADDR_W-1:0] exp_addr;
  logic              redirect;
  logic              rsp_here;
  logic              push;
  logic              pop;
  logic              issue;

  always_comb begin
    misaligned = (bus.inst_addr[1:0] != 2'b00);

    // Where the core should be if it kept going straight. A dropped request no
    // longer counts, otherwise the redirect would re-fire until its response.
    if (!fifo_empty)             exp_addr = head.addr;
    else if (pend && !pend_drop) exp_addr = pend_addr;
    else                         exp_addr = fp;

    redirect = !done && (bus.inst_addr != exp_addr);
    pop      = rst_n && !fifo_empty && (head.addr == bus.inst_addr) && !done && !misaligned;
    rsp_here = pend && bus.im_rvalid;
    push     = rsp_here && !pend_drop && !redirect && !done;

    // Fullness is judged on post-pop/post-write occupancy so pop, write and a new
    // request can share a cycle.
    occ_next = fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    issue    = rst_n && (!pend || rsp_here) && (occ_next < (PW+1)'(EFF_DEPTH))
               && !done && !redirect && !misaligned;

    wr_entry.addr = pend_addr;
    wr_entry.data = bus.im_rdata;
  end

  assign bus.in_valid = pop;
  assign bus.inst     = pop ? head.data : '0;
  assign bus.im_rd    = issue;
  assign bus.im_addr  = issue ? fp : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp        <= '0;
      pend      <= 1'b0;
      pend_drop <= 1'b0;
      pend_addr <= '0;
      exec_cnt  <= '0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (misaligned) addr_err <= 1'b1;

      if (pop) begin
        exec_cnt <= exec_cnt + 1'b1;
        if (exec_cnt == CNT_W'(EXEC_NUM - 1)) done <= 1'b1;
      end

      if (redirect)   fp <= bus.inst_addr;
      else if (issue) fp <= fp + ADDR_W'(4);

      if (issue) begin
        pend      <= 1'b1;
        pend_drop <= 1'b0;
        pend_addr <= fp;
      end else if (rsp_here) begin
        pend      <= 1'b0;
        pend_drop <= 1'b0;
      end else if (pend && (redirect || done)) begin
        pend_drop <= 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (wr_entry),
    .head     (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int EXEC_NUM = 20;
  localparam int DEPTH    = 4;
`ifdef FETCH_PREFETCH_EN
  localparam int EFF_DEPTH = DEPTH;
  localparam bit PREFETCH  = 1'b1;
`else
  localparam int EFF_DEPTH = 1;
  localparam bit PREFETCH  = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic done;
  logic addr_err;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(32)) ifc ();

  inst_fetch_unit #(.DEPTH(DEPTH), .EXEC_NUM(EXEC_NUM), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .done     (done),
    .addr_err (addr_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference environment ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  logic [31:0] mem [256];     // instruction memory contents
  req_t        mem_q[$];      // requests in flight (memory model)
  logic [31:0] exp_q[$];      // words the core must see, in order, for the current valid
  int          cyc;
  int          lat;
  bit          lat_rand;
  int          delivered;
  bit          err_seen;
  int          core_mode;     // 0 straight, 1 random branches, 2 single jump
  logic [31:0] jump_from;
  logic [31:0] jump_to;

  bit          v_seen;
  bit          rd_seen;
  logic [31:0] v_addr;
  logic [31:0] rd_addr;
  int          t_obs;

  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, then drive the next cycle's inputs at posedge+1.
  task automatic tick();
    int          l;
    logic [31:0] nxt;
    @(negedge clk);
    t_obs   = cyc;
    v_seen  = 1'b0;
    rd_seen = 1'b0;
    rd_addr = 32'hFFFF_FFFF;
    nxt     = ifc.inst_addr;
    if (!rst_n) begin
      chk("rst_in_valid", 32'(ifc.in_valid), 32'd0);
      chk("rst_im_rd", 32'(ifc.im_rd), 32'd0);
      mem_q.delete();
      delivered = 0;
      err_seen  = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(delivered >= EXEC_NUM));
      chk("addr_err", 32'(addr_err), 32'(err_seen));
      if (ifc.in_valid) begin
        v_seen = 1'b1;
        v_addr = ifc.inst_addr;
        exp_q.push_back(mem[ifc.inst_addr[9:2]]);
        chk("inst", ifc.inst, exp_q.pop_front());
        chk("valid_aligned", 32'(ifc.inst_addr[1:0]), 32'd0);
        chk("valid_not_done", 32'(done), 32'd0);
        delivered++;
      end else begin
        chk("inst_idle", ifc.inst, 32'd0);
      end
      if (ifc.im_rd) begin
        rd_seen = 1'b1;
        rd_addr = ifc.im_addr;
        chk("rd_one_outstanding", 32'(mem_q.size()), 32'd0);
        chk("rd_aligned", 32'(ifc.im_addr[1:0]), 32'd0);
        chk("rd_not_done", 32'(done), 32'd0);
        l = lat_rand ? int'($urandom_range(1, 4)) : lat;
        mem_q.push_back('{due: cyc + l, addr: ifc.im_addr});
      end
      if (ifc.inst_addr[1:0] != 2'b00) err_seen = 1'b1;
    end
    if (v_seen) begin
      case (core_mode)
        0:       nxt = v_addr + 32'd4;
        1:       nxt = ($urandom_range(0, 3) == 0) ?
                       {22'b0, 8'($urandom_range(0, 255)), 2'b00} : v_addr + 32'd4;
        default: nxt = (v_addr == jump_from) ? jump_to : v_addr + 32'd4;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    ifc.inst_addr = nxt;
    ifc.im_rvalid = 1'b0;
    ifc.im_rdata  = '0;
    if (rst_n && mem_q.size() > 0 && mem_q[0].due == cyc) begin
      ifc.im_rvalid = 1'b1;
      ifc.im_rdata  = mem[mem_q[0].addr[9:2]];
      void'(mem_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    ifc.inst_addr = '0;
    ifc.im_rvalid = 1'b0;
    ifc.im_rdata  = '0;
    tick();
    tick();
    rst_n         = 1'b1;
    ifc.inst_addr = '0;
    ifc.im_rvalid = 1'b0;
    ifc.im_rdata  = '0;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (delivered < target && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(delivered >= target), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  int          t_rd;
  int          t_v;
  int          t_r;
  int          prev_v;
  int          issued;
  logic [31:0] prev_rd;
  bit          jumped;
  bit          got40;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    delivered = 0;
    err_seen  = 1'b0;
    lat       = 2;
    lat_rand  = 1'b0;
    core_mode = 0;
    jump_from = '0;
    jump_to   = '0;
    ifc.inst_addr = '0;
    ifc.im_rvalid = 1'b0;
    ifc.im_rdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Cold start, L=2: first request right after reset, data usable L+1 later.
    do_reset();
    tick();
    chk("cold_rd", 32'(rd_seen), 32'd1);
    chk("cold_rd_addr", rd_addr, 32'h0);
    chk("cold_no_valid", 32'(v_seen), 32'd0);
    t_rd = t_obs;
    t_v  = -1;
    for (int i = 0; i < 12 && t_v < 0; i++) begin
      tick();
      if (v_seen) t_v = t_obs;
    end
    chk("cold_latency", 32'(t_v - t_rd), 32'(lat + 1));

    // Reset during active fetch.
    run_until(3, 60, "warm");
    do_reset();
    tick();
    chk("rst_first_rd", 32'(rd_seen), 32'd1);
    chk("rst_first_rd_addr", rd_addr, 32'h0);
    chk("rst_first_valid", 32'(v_seen), 32'd0);

    // Straight line, L=1, through 0x3C, then on to the budget.
    lat = 1;
    do_reset();
    t_r     = cyc;
    prev_v  = -1;
    issued  = 0;
    prev_rd = '0;
    for (int i = 0; i < 120 && delivered < 16; i++) begin
      tick();
      if (rd_seen) begin
        if (issued > 0) chk("seq_rd_step", rd_addr, prev_rd + 32'd4);
        else            chk("seq_rd_first", rd_addr, 32'h0);
        prev_rd = rd_addr;
        issued++;
      end
      chk("seq_occupancy", 32'((issued - delivered) <= EFF_DEPTH), 32'd1);
      if (v_seen) begin
        if (prev_v >= 0) chk("seq_gap", 32'(t_obs - prev_v), 32'(PREFETCH ? 1 : lat + 1));
        else             chk("seq_cold_gap", 32'(t_obs - t_r), 32'd2);
        prev_v = t_obs;
      end
    end
    chk("seq_count", 32'(delivered), 32'd16);

    // Budget: stop after EXEC_NUM, then stay silent.
    run_until(EXEC_NUM, 120, "budget");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_done_valid", 32'(v_seen), 32'd0);
      chk("post_done_rd", 32'(rd_seen), 32'd0);
    end
    chk("done_sticky", 32'(done), 32'd1);

    // Redirect 0x10 -> 0x40 with L=3.
    lat       = 3;
    core_mode = 2;
    jump_from = 32'h10;
    jump_to   = 32'h40;
    do_reset();
    jumped = 1'b0;
    got40  = 1'b0;
    t_rd   = -1;
    t_v    = -1;
    for (int i = 0; i < 200 && delivered < 10; i++) begin
      tick();
      if (jumped && rd_seen && !got40) begin
        chk("redir_rd_addr", rd_addr, 32'h40);
        got40 = 1'b1;
        t_rd  = t_obs;
      end
      if (v_seen && v_addr == 32'h40) begin
        t_v = t_obs;
        chk("redir_latency", 32'(t_v - t_rd), 32'(lat + 1));
      end
      if (v_seen && v_addr == jump_from) jumped = 1'b1;
    end
    chk("redir_reached", 32'(t_v >= 0), 32'd1);
    chk("redir_count", 32'(delivered), 32'd10);

    // Misaligned target 0x6.
    lat       = 1;
    jump_from = 32'h4;
    jump_to   = 32'h6;
    do_reset();
    run_until(2, 40, "mis_pre");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mis_addr_held", ifc.inst_addr, 32'h6);
      chk("mis_no_valid", 32'(v_seen), 32'd0);
      chk("mis_no_rd", 32'(rd_seen), 32'd0);
    end
    chk("mis_err", 32'(addr_err), 32'd1);
    ifc.inst_addr = 32'h8;
    core_mode     = 0;
    run_until(5, 60, "mis_recover");
    chk("mis_sticky", 32'(addr_err), 32'd1);

    // Random branches and random latency.
    lat_rand  = 1'b1;
    core_mode = 1;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      run_until(EXEC_NUM, 600, "rand");
      for (int i = 0; i < 5; i++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
